// File: rtl/rr_radar_xmtr_if.sv
// Signal bundle between the AGC-side harness and the rendezvous-radar transmitter.
// The transmitter takes the slave side; the harness or bench drives the master side.
interface rr_radar_xmtr_if;
  logic        RRSYNC;
  logic        RRRANG;
  logic        RRRARA;
  logic        wr_range;
  logic        wr_rate;
  logic [14:0] din;
  logic        clr_err;
  logic        RRIN1;
  logic        RRIN0;
  logic        busy;
  logic [3:0]  bitcnt;
  logic        word_done;
  logic        word_abort;
  logic        overrun;
  logic        sel_err;

  modport master (
    output RRSYNC, RRRANG, RRRARA, wr_range, wr_rate, din, clr_err,
    input  RRIN1, RRIN0, busy, bitcnt, word_done, word_abort, overrun, sel_err
  );

  modport slave (
    input  RRSYNC, RRRANG, RRRARA, wr_range, wr_rate, din, clr_err,
    output RRIN1, RRIN0, busy, bitcnt, word_done, word_abort, overrun, sel_err
  );
endinterface

// File: rtl/rr_radar_xmtr.sv
// Rendezvous-radar serial transmitter: returns one bit of a 15-bit range or
// range-rate word, MSB first, on RRIN1/RRIN0 for each RRSYNC gating pulse.
module rr_radar_xmtr #(
  parameter int BIT_DELAY = 2,
  parameter int PULSE_W   = 1,
  parameter int TIMEOUT   = 4096
) (
  input logic            CLOCK,
  input logic            rst_,
  rr_radar_xmtr_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]  state;
  logic [14:0] range_h;
  logic [14:0] rate_h;
  logic [14:0] sr;
  logic        sync_q;
  logic        sync_edge;
  logic [3:0]  dcnt;
  logic [2:0]  pcnt;
  logic [15:0] tcnt;
  logic [3:0]  bit_q;
  logic        one_q;
  logic        zero_q;
  logic        done_q;
  logic        abort_q;
  logic        ovr_q;
  logic        sel_q;
  logic        ovr_set;
  logic        sel_set;

  // A held-high RRSYNC only counts once, on its low-to-high transition.
  assign sync_edge = bus.RRSYNC & ~sync_q;
  assign ovr_set   = sync_edge && (state == DELAY || state == PULSE);
  assign sel_set   = sync_edge && (state == IDLE) && (bus.RRRANG == bus.RRRARA);

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      sync_q  <= 1'b0;
      range_h <= '0;
      rate_h  <= '0;
    end else begin
      sync_q <= bus.RRSYNC;
      if (bus.wr_range) range_h <= bus.din;
      if (bus.wr_rate)  rate_h  <= bus.din;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      sr      <= '0;
      dcnt    <= '0;
      pcnt    <= '0;
      tcnt    <= '0;
      bit_q   <= '0;
      one_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_edge) begin
            if (bus.RRRANG == bus.RRRARA) sr <= '0;
            else if (bus.RRRANG)          sr <= range_h;
            else                          sr <= rate_h;
            dcnt  <= '0;
            state <= DELAY;
          end
        end
        DELAY: begin
          if (dcnt == 4'(BIT_DELAY - 1)) begin
            one_q  <= sr[14];
            zero_q <= ~sr[14];
            pcnt   <= '0;
            state  <= PULSE;
          end else begin
            dcnt <= dcnt + 4'd1;
          end
        end
        PULSE: begin
          if (pcnt == 3'(PULSE_W - 1)) begin
            one_q  <= 1'b0;
            zero_q <= 1'b0;
            sr     <= {sr[13:0], 1'b0};
            if (bit_q == 4'd14) begin
              bit_q  <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              bit_q <= bit_q + 4'd1;
              tcnt  <= '0;
              state <= WAIT;
            end
          end else begin
            pcnt <= pcnt + 3'd1;
          end
        end
        WAIT: begin
          // The word selection is kept from word start; a new edge just schedules the next bit.
          if (sync_edge) begin
            dcnt  <= '0;
            state <= DELAY;
          end else if (tcnt == 16'(TIMEOUT - 1)) begin
            abort_q <= 1'b1;
            bit_q   <= '0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A freshly detected error beats a simultaneous clear.
  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      ovr_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      if (ovr_set)          ovr_q <= 1'b1;
      else if (bus.clr_err) ovr_q <= 1'b0;
      if (sel_set)          sel_q <= 1'b1;
      else if (bus.clr_err) sel_q <= 1'b0;
    end
  end

  assign bus.RRIN1      = one_q;
  assign bus.RRIN0      = zero_q;
  assign bus.busy       = (state != IDLE);
  assign bus.bitcnt     = bit_q;
  assign bus.word_done  = done_q;
  assign bus.word_abort = abort_q;
  assign bus.overrun    = ovr_q;
  assign bus.sel_err    = sel_q;

endmodule

// File: tb/tb_rr_radar_xmtr.sv
// Bench for rr_radar_xmtr: directed scenarios plus random sync traffic, all
// checked every cycle against a timing-arithmetic model of the transmitter.
module tb_rr_radar_xmtr;

  localparam int BD = 2;
  localparam int PW = 1;
  localparam int TO = 16;

  logic CLOCK = 1'b0;
  logic rst_  = 1'b0;

  rr_radar_xmtr_if bus();

  rr_radar_xmtr #(.BIT_DELAY(BD), .PULSE_W(PW), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: word in flight is described by its last accepted edge cycle and bit index.
  bit          mActive = 0;
  int          mE = 0;
  int          mB = 0;
  logic [14:0] mWord = '0;
  logic        mOvr = 0, mSel = 0, mPrev = 0;
  logic [14:0] mRange = '0, mRate = '0;

  int          onesCount = 0, zerosCount = 0, doneCount = 0, abortCount = 0;
  int          lastEdgeCyc = 0, lastPulseCyc = 0, lag = 0, abortLag = 0;
  logic [14:0] capBits = '0;
  logic        prevPulse = 0;

  logic        e1, e0, eb, ed, ea, edgeNow, ovrSet, selSet, pulseNow;
  logic [3:0]  ebc;
  int          pe;
  bit          freeNow;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic modelOutputs(input int c, output logic one, output logic zero, output logic busy,
                              output logic done, output logic abrt, output logic [3:0] bc);
    int pend;
    one = 0; zero = 0; busy = 0; done = 0; abrt = 0; bc = '0;
    if (mActive) begin
      pend = mE + BD + PW;
      if (c <= pend) begin
        busy = 1;
        bc   = 4'(mB);
        if (c > mE + BD) begin
          one  = mWord[14 - mB];
          zero = ~mWord[14 - mB];
        end
      end else if (mB == 14) begin
        done = (c == pend + 1);
      end else if (c < pend + 1 + TO) begin
        busy = 1;
        bc   = 4'(mB + 1);
      end else begin
        abrt = (c == pend + 1 + TO);
      end
    end
  endtask

  // Per-cycle compare and model update, sampled mid-cycle.
  always @(negedge CLOCK) begin
    cyc++;
    if (!rst_) begin
      mActive = 0; mOvr = 0; mSel = 0; mPrev = 0; mRange = '0; mRate = '0; prevPulse = 0;
      checkOutput("reset_outputs",
                  16'({bus.RRIN1, bus.RRIN0, bus.busy, bus.bitcnt, bus.word_done,
                       bus.word_abort, bus.overrun, bus.sel_err}), 16'h0);
    end else begin
      modelOutputs(cyc, e1, e0, eb, ed, ea, ebc);
      checkOutput("RRIN1", 16'(bus.RRIN1), 16'(e1));
      checkOutput("RRIN0", 16'(bus.RRIN0), 16'(e0));
      checkOutput("busy", 16'(bus.busy), 16'(eb));
      checkOutput("bitcnt", 16'(bus.bitcnt), 16'(ebc));
      checkOutput("word_done", 16'(bus.word_done), 16'(ed));
      checkOutput("word_abort", 16'(bus.word_abort), 16'(ea));
      checkOutput("overrun", 16'(bus.overrun), 16'(mOvr));
      checkOutput("sel_err", 16'(bus.sel_err), 16'(mSel));

      pulseNow = bus.RRIN1 | bus.RRIN0;
      if (pulseNow && !prevPulse) begin
        capBits      = {capBits[13:0], bus.RRIN1};
        lag          = cyc - lastEdgeCyc;
        lastPulseCyc = cyc;
      end
      if (bus.RRIN1) onesCount++;
      if (bus.RRIN0) zerosCount++;
      if (bus.word_done) doneCount++;
      if (bus.word_abort) begin
        abortCount++;
        abortLag = cyc - lastPulseCyc;
      end
      prevPulse = pulseNow;

      edgeNow = bus.RRSYNC && !mPrev;
      ovrSet  = 0;
      selSet  = 0;
      if (edgeNow) begin
        lastEdgeCyc = cyc;
        pe      = mE + BD + PW;
        freeNow = !mActive || (cyc > pe && (mB == 14 || cyc >= pe + 1 + TO));
        if (freeNow) begin
          mActive = 1; mE = cyc; mB = 0;
          if (bus.RRRANG == bus.RRRARA) begin
            mWord  = '0;
            selSet = 1;
          end else if (bus.RRRANG) mWord = mRange;
          else mWord = mRate;
        end else if (cyc <= pe) begin
          ovrSet = 1;
        end else begin
          mE = cyc;
          mB = mB + 1;
        end
      end
      mOvr = ovrSet | (mOvr & ~bus.clr_err);
      mSel = selSet | (mSel & ~bus.clr_err);
      if (bus.wr_range) mRange = bus.din;
      if (bus.wr_rate)  mRate  = bus.din;
      mPrev = bus.RRSYNC;
    end
  end

  task automatic applyStimulus(input logic s, input logic wrg, input logic wrt,
                               input logic [14:0] d, input logic clr);
    @(posedge CLOCK);
    #1;
    bus.RRSYNC   = s;
    bus.wr_range = wrg;
    bus.wr_rate  = wrt;
    bus.din      = d;
    bus.clr_err  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0);
  endtask

  task automatic syncs(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 0, '0, 0);
      idle(spacing - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  int d0, d1, d2, hold, gap;

  initial begin
    bus.RRSYNC = 0; bus.RRRANG = 0; bus.RRRARA = 0; bus.wr_range = 0;
    bus.wr_rate = 0; bus.din = '0; bus.clr_err = 0;
    repeat (3) @(posedge CLOCK);
    #1 rst_ = 1'b1;
    idle(1);
    checkOutput("reset_state",
                16'({bus.RRIN1, bus.RRIN0, bus.busy, bus.bitcnt, bus.word_done,
                     bus.word_abort, bus.overrun, bus.sel_err}), 16'h0);

    $display("[TB] range word");
    bus.RRRANG = 1; bus.RRRARA = 0;
    applyStimulus(0, 1, 0, 15'h5A5A, 0);
    d0 = doneCount;
    syncs(15, 8);
    idle(2);
    checkOutput("range_bits", 16'(capBits), 16'b0101101001011010);
    checkOutput("range_lag", 16'(lag), 16'd3);
    checkOutput("range_done", 16'(doneCount - d0), 16'd1);
    checkOutput("range_bitcnt", 16'(bus.bitcnt), 16'd0);

    $display("[TB] rate words at minimum spacing");
    bus.RRRANG = 0; bus.RRRARA = 1;
    applyStimulus(0, 0, 1, 15'h7FFF, 0);
    d0 = onesCount; d1 = zerosCount;
    syncs(15, BD + PW + 1);
    idle(3);
    checkOutput("rate_ones", 16'(onesCount - d0), 16'd15);
    checkOutput("rate_ones_zero", 16'(zerosCount - d1), 16'd0);
    applyStimulus(0, 0, 1, 15'h0000, 0);
    d0 = onesCount; d1 = zerosCount;
    syncs(15, BD + PW + 1);
    idle(3);
    checkOutput("rate_zeros", 16'(zerosCount - d1), 16'd15);
    checkOutput("rate_zeros_one", 16'(onesCount - d0), 16'd0);
    checkOutput("rate_no_overrun", 16'(bus.overrun), 16'd0);

    $display("[TB] overrun");
    bus.RRRANG = 1; bus.RRRARA = 0;
    d0 = onesCount + zerosCount;
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    idle(4);
    checkOutput("ovr_flag", 16'(bus.overrun), 16'd1);
    checkOutput("ovr_bitcnt", 16'(bus.bitcnt), 16'd1);
    checkOutput("ovr_pulses", 16'(onesCount + zerosCount - d0), 16'd1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("ovr_cleared", 16'(bus.overrun), 16'd0);
    idle(25);

    $display("[TB] selection error");
    bus.RRRANG = 1; bus.RRRARA = 1;
    d0 = onesCount; d1 = zerosCount;
    syncs(15, 5);
    idle(3);
    checkOutput("sel_flag", 16'(bus.sel_err), 16'd1);
    checkOutput("sel_zeros", 16'(zerosCount - d1), 16'd15);
    checkOutput("sel_ones", 16'(onesCount - d0), 16'd0);
    applyStimulus(0, 0, 0, '0, 1);

    $display("[TB] timeout");
    bus.RRRANG = 1; bus.RRRARA = 0;
    applyStimulus(0, 1, 0, 15'h2AAA, 0);
    d0 = abortCount;
    syncs(5, 6);
    idle(25);
    checkOutput("to_abort", 16'(abortCount - d0), 16'd1);
    checkOutput("to_abort_lag", 16'(abortLag), 16'(TO + 1));
    checkOutput("to_busy", 16'(bus.busy), 16'd0);
    checkOutput("to_bitcnt", 16'(bus.bitcnt), 16'd0);
    applyStimulus(0, 1, 0, 15'h4001, 0);
    d0 = doneCount;
    syncs(15, 6);
    idle(3);
    checkOutput("to_restart_bits", 16'(capBits), 16'h4001);
    checkOutput("to_restart_done", 16'(doneCount - d0), 16'd1);

    $display("[TB] reset mid-pulse");
    applyStimulus(0, 1, 0, 15'h7FFF, 0);
    d0 = doneCount;
    syncs(6, 8);
    applyStimulus(1, 0, 0, '0, 0);
    idle(3);
    checkOutput("rst_pre_pulse", 16'(bus.RRIN1), 16'd1);
    checkOutput("rst_pre_bitcnt", 16'(bus.bitcnt), 16'd6);
    #2 rst_ = 1'b0;
    #1;
    checkOutput("rst_immediate",
                16'({bus.RRIN1, bus.RRIN0, bus.busy, bus.bitcnt, bus.word_done,
                     bus.word_abort, bus.overrun, bus.sel_err}), 16'h0);
    idle(2);
    @(posedge CLOCK);
    #1 rst_ = 1'b1;
    idle(20);
    checkOutput("rst_no_done", 16'(doneCount - d0), 16'd0);

    $display("[TB] mid-word write");
    applyStimulus(0, 1, 0, 15'h1234, 0);
    syncs(3, 8);
    applyStimulus(0, 1, 0, 15'h6B6B, 0);
    syncs(12, 8);
    idle(2);
    checkOutput("mw_current", 16'(capBits), 16'h1234);
    syncs(15, 8);
    idle(2);
    checkOutput("mw_next", 16'(capBits), 16'h6B6B);

    $display("[TB] random traffic");
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.RRRANG = 1'($urandom_range(0, 1));
        bus.RRRARA = 1'($urandom_range(0, 1));
      end
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 6);
      for (int h = 0; h < hold; h++)
        applyStimulus(1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      15'($urandom), $urandom_range(0, 9) == 0);
      for (int g = 0; g < gap; g++)
        applyStimulus(0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      15'($urandom), $urandom_range(0, 9) == 0);
    end
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
